// File: rtl/riscv_ex_md_pkg.sv
// Shared decode constants, FSM state type and operand-signedness helpers
// for the execute stage and its iterative multiply/divide unit.
package riscv_ex_md_pkg;

  // ALU funct3 decode (muldiv = 0)
  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SRL  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  // M-extension funct3 decode (muldiv = 1)
  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    EXMD_IDLE = 2'd0,
    EXMD_CALC = 2'd1,
    EXMD_FIX  = 2'd2
  } exmd_state_t;

  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == FUNCT3_MUL) || (op == FUNCT3_MULH) || (op == FUNCT3_MULHSU) ||
           (op == FUNCT3_DIV) || (op == FUNCT3_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == FUNCT3_MUL) || (op == FUNCT3_MULH) ||
           (op == FUNCT3_DIV) || (op == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/riscv_ex_md_muldiv.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, one bit per CALC cycle, sign fix-up in FIX.
module riscv_muldiv
  import riscv_ex_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN - 1);

  exmd_state_t       state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0]   mag_reg, mag_next;
  logic [2:0]        op_reg, op_next;
  logic              sa_reg, sa_next;
  logic              sb_reg, sb_next;
  logic              bzero_reg, bzero_next;

  logic              sa_in, sb_in;
  logic [XLEN-1:0]   ma_in, mb_in;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  assign sa_in = op_signed_a(op) & a[XLEN-1];
  assign sb_in = op_signed_b(op) & b[XLEN-1];
  assign ma_in = sa_in ? -a : a;
  assign mb_in = sb_in ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, mag_reg};
  // Divide: acc = {partial remainder, dividend/quotient bits}
  assign div_diff = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, mag_reg};

  assign prod = (sa_reg ^ sb_reg) ? -acc_reg : acc_reg;
  assign quo  = acc_reg[XLEN-1:0];
  assign rem  = acc_reg[2*XLEN-1:XLEN];

  assign idle = (state_reg == EXMD_IDLE);
  assign done = (state_reg == EXMD_FIX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EXMD_IDLE;
      count_reg <= '0;
      acc_reg   <= '0;
      mag_reg   <= '0;
      op_reg    <= '0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      bzero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      acc_reg   <= acc_next;
      mag_reg   <= mag_next;
      op_reg    <= op_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      bzero_reg <= bzero_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    acc_next   = acc_reg;
    mag_next   = mag_reg;
    op_next    = op_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    bzero_next = bzero_reg;
    case (state_reg)
      EXMD_IDLE: begin
        if (start) begin
          state_next = EXMD_CALC;
          count_next = CNT_LOAD;
          op_next    = op;
          sa_next    = sa_in;
          sb_next    = sb_in;
          bzero_next = (b == '0);
          if (op[2]) begin
            acc_next = {{XLEN{1'b0}}, ma_in};
            mag_next = mb_in;
          end else begin
            acc_next = {{XLEN{1'b0}}, mb_in};
            mag_next = ma_in;
          end
        end
      end
      EXMD_CALC: begin
        if (op_reg[2]) begin
          if (!div_diff[XLEN])
            acc_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
          else
            acc_next = {acc_reg[2*XLEN-2:0], 1'b0};
        end else begin
          if (acc_reg[0])
            acc_next = {mul_sum, acc_reg[XLEN-1:1]};
          else
            acc_next = {1'b0, acc_reg[2*XLEN-1:1]};
        end
        if (count_reg == '0) begin
          state_next = EXMD_FIX;
        end else begin
          count_next = count_reg - CW'(1);
        end
      end
      EXMD_FIX: begin
        state_next = EXMD_IDLE;
      end
      default: begin
        state_next = EXMD_IDLE;
      end
    endcase
  end

  // Divide-by-zero quotient is forced; remainder of |a| re-signed gives a.
  always_comb begin
    result = '0;
    case (op_reg)
      FUNCT3_MUL:                             result = prod[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: result = prod[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:
        result = bzero_reg ? {XLEN{1'b1}} : ((sa_reg ^ sb_reg) ? -quo : quo);
      FUNCT3_REM, FUNCT3_REMU:
        result = sa_reg ? -rem : rem;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/riscv_ex_md.sv
// Execute stage: single-cycle ALU inline plus an iterative multiply/divide
// unit; decode is stalled through in_ready while an M operation is in flight.
module riscv_ex_md
  import riscv_ex_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rdi,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [SHW-1:0]  shamt,
  input  logic [2:0]      funct3,
  input  logic            invertb,
  input  logic            muldiv,
  input  logic            load,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd,
  output logic            memfetch,
  output logic            out_valid
);

  logic                    accept;
  logic                    md_start;
  logic                    md_idle;
  logic                    md_done;
  logic [XLEN-1:0]         md_result;
  logic [4:0]              md_rd_reg;
  logic                    md_load_reg;
  logic [XLEN-1:0]         alu_result;
  logic signed [XLEN-1:0]  sra_result;

  assign in_ready = rst & md_idle;
  assign accept   = in_valid & in_ready;
  assign md_start = accept & muldiv;

  riscv_muldiv #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op     (funct3),
    .a      (a),
    .b      (b),
    .idle   (md_idle),
    .done   (md_done),
    .result (md_result)
  );

  // Kept separate so the arithmetic shift is not flattened to logical by context
  assign sra_result = $signed(a) >>> shamt;

  always_comb begin
    alu_result = '0;
    case (funct3)
      FUNCT3_ADD:  alu_result = invertb ? (a - b) : (a + b);
      FUNCT3_SLL:  alu_result = a << shamt;
      FUNCT3_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      FUNCT3_SLTU: alu_result = {{(XLEN-1){1'b0}}, (a < b)};
      FUNCT3_XOR:  alu_result = a ^ b;
      FUNCT3_SRL:  alu_result = invertb ? sra_result : (a >> shamt);
      FUNCT3_OR:   alu_result = a | b;
      FUNCT3_AND:  alu_result = a & b;
      default:     alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result      <= '0;
      rd          <= '0;
      memfetch    <= 1'b0;
      out_valid   <= 1'b0;
      md_rd_reg   <= '0;
      md_load_reg <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !muldiv) begin
        result    <= alu_result;
        rd        <= rdi;
        memfetch  <= load;
        out_valid <= 1'b1;
      end
      if (md_start) begin
        md_rd_reg   <= rdi;
        md_load_reg <= load;
      end
      if (md_done) begin
        result    <= md_result;
        rd        <= md_rd_reg;
        memfetch  <= md_load_reg;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_ex_md.sv
// Scoreboard bench for riscv_ex_md: XLEN=32 and XLEN=64 instances, directed
// corner cases plus random ops checked against an arithmetic reference model.
module tb_riscv_ex_md;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        mf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid32, in_valid64;
  logic [4:0]  rdi;
  logic [63:0] a, b;
  logic [5:0]  shamt;
  logic [2:0]  funct3;
  logic        invertb, muldiv, load;

  logic        rdy32, rdy64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [4:0]  rd32, rd64;
  logic        mf32, mf64, ov32, ov64;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_ex_md #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(rdy32), .rdi(rdi),
    .a(a[31:0]), .b(b[31:0]), .shamt(shamt[4:0]), .funct3(funct3), .invertb(invertb),
    .muldiv(muldiv), .load(load), .result(res32), .rd(rd32), .memfetch(mf32),
    .out_valid(ov32)
  );

  riscv_ex_md #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(rdy64), .rdi(rdi),
    .a(a), .b(b), .shamt(shamt), .funct3(funct3), .invertb(invertb),
    .muldiv(muldiv), .load(load), .result(res64), .rd(rd64), .memfetch(mf64),
    .out_valid(ov64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the RISC-V definitions, truncated to w bits.
  function automatic logic [63:0] ref_model(input int w, input logic [2:0] f3, input logic md,
                                            input logic inv, input logic [63:0] av,
                                            input logic [63:0] bv, input int sh);
    logic signed [127:0] as_v, bs_v, au_v, bu_v, t, minv;
    logic [127:0] mask;
    mask = (w == 64) ? {64'h0, {64{1'b1}}} : {96'h0, 32'hFFFF_FFFF};
    au_v = $signed({64'h0, av & mask[63:0]});
    bu_v = $signed({64'h0, bv & mask[63:0]});
    as_v = (w == 64) ? $signed({{64{av[63]}}, av}) : $signed({{96{av[31]}}, av[31:0]});
    bs_v = (w == 64) ? $signed({{64{bv[63]}}, bv}) : $signed({{96{bv[31]}}, bv[31:0]});
    minv = -(128'sd1 <<< (w - 1));
    t = 0;
    if (md) begin
      case (f3)
        3'd0: t = as_v * bs_v;
        3'd1: begin t = as_v * bs_v; t = t >>> w; end
        3'd2: begin t = as_v * bu_v; t = t >>> w; end
        3'd3: begin t = au_v * bu_v; t = t >>> w; end
        3'd4: if (bu_v == 0) t = -1;
              else if (as_v == minv && bs_v == -1) t = as_v;
              else t = as_v / bs_v;
        3'd5: t = (bu_v == 0) ? -1 : au_v / bu_v;
        3'd6: if (bu_v == 0) t = as_v;
              else if (as_v == minv && bs_v == -1) t = 0;
              else t = as_v % bs_v;
        default: t = (bu_v == 0) ? au_v : au_v % bu_v;
      endcase
    end else begin
      case (f3)
        3'd0: t = inv ? (as_v - bs_v) : (as_v + bs_v);
        3'd1: t = au_v << sh;
        3'd2: t = (as_v < bs_v) ? 1 : 0;
        3'd3: t = (au_v < bu_v) ? 1 : 0;
        3'd4: t = au_v ^ bu_v;
        3'd5: t = inv ? (as_v >>> sh) : (au_v >> sh);
        3'd6: t = au_v | bu_v;
        default: t = au_v & bu_v;
      endcase
    end
    return t[63:0] & mask[63:0];
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] v, m;
    m = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    case ($urandom_range(0, 5))
      0: v = 64'h0;
      1: v = {64{1'b1}};
      2: v = 64'h1 << (w - 1);
      3: v = 64'h1;
      default: v = {$urandom, $urandom};
    endcase
    return v & m;
  endfunction

  // Presents an op from a negedge, waits (bounded) for accept, logs expectation.
  task automatic issue(input bit w64, input logic [2:0] f3, input logic md, input logic inv,
                       input logic [63:0] av, input logic [63:0] bv, input int sh,
                       input logic [4:0] rdv, input logic ld);
    int   guard;
    int   w;
    exp_t e;
    w = w64 ? 64 : 32;
    funct3 = f3; muldiv = md; invertb = inv; a = av; b = bv;
    shamt = 6'(sh); rdi = rdv; load = ld;
    if (w64) in_valid64 = 1'b1; else in_valid32 = 1'b1;
    guard = 0;
    while (!(w64 ? rdy64 : rdy32) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait_expired", 64'(guard >= 500), 64'h0);
    @(posedge clk);
    #1;
    last_acc = cyc;
    e.res = ref_model(w, f3, md, inv, av, bv, sh);
    e.rd  = rdv;
    e.mf  = ld;
    e.cyc = cyc + (md ? w + 1 : 0);
    if (w64) q64.push_back(e); else q32.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int g;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    g = 0;
    while ((q32.size() != 0 || q64.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", 64'(q32.size() + q64.size()), 64'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ov32) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL x32_unexpected_out_valid actual=1 required=0 rd=%0d cycle=%0d", rd32, cyc);
      end else begin
        e = q32.pop_front();
        chk("x32_result", {32'h0, res32}, e.res);
        chk("x32_rd", 64'(rd32), 64'(e.rd));
        chk("x32_memfetch", 64'(mf32), 64'(e.mf));
        chk("x32_cycle", 64'(cyc), 64'(e.cyc));
        $display("txn x32 rd=%0d result=%h memfetch=%0d cycle=%0d", rd32, res32, mf32, cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov64) begin
      if (q64.size() == 0) begin
        checks++; failures++;
        $display("FAIL x64_unexpected_out_valid actual=1 required=0 rd=%0d cycle=%0d", rd64, cyc);
      end else begin
        e = q64.pop_front();
        chk("x64_result", res64, e.res);
        chk("x64_rd", 64'(rd64), 64'(e.rd));
        chk("x64_memfetch", 64'(mf64), 64'(e.mf));
        chk("x64_cycle", 64'(cyc), 64'(e.cyc));
        $display("txn x64 rd=%0d result=%h memfetch=%0d cycle=%0d", rd64, res64, mf64, cyc);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    rst = 1'b0; in_valid32 = 1'b0; in_valid64 = 1'b0;
    rdi = '0; a = '0; b = '0; shamt = '0; funct3 = '0;
    invertb = 1'b0; muldiv = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_result", {32'h0, res32}, 64'h0);
    chk("reset_rd", 64'(rd32), 64'h0);
    chk("reset_memfetch", 64'(mf32), 64'h0);
    chk("reset_out_valid", 64'(ov32), 64'h0);
    chk("reset_in_ready", 64'(rdy32), 64'h0);
    chk("reset_in_ready64", 64'(rdy64), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(rdy32), 64'h1);

    // Back-to-back ALU stream
    issue(0, 3'd0, 0, 0, 40, 2, 0, 4, 0);
    acc0 = last_acc;
    issue(0, 3'd0, 0, 1, 40, 5, 0, 2, 1);
    issue(0, 3'd1, 0, 0, 3, 0, 2, 5, 0);
    issue(0, 3'd5, 0, 1, 64'h8000_0000, 0, 4, 6, 0);
    chk("alu_back_to_back", 64'(last_acc - acc0), 64'h3);
    drain();

    // MUL -3*7: stall length and latency
    issue(0, 3'd0, 1, 0, 64'hFFFF_FFFD, 7, 0, 7, 1);
    in_valid32 = 1'b0;
    n = 0;
    while (!rdy32 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("mul_in_ready_low_cycles", 64'(n), 64'd33);
    drain();
    issue(0, 3'd3, 1, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 8, 0);
    drain();

    // Divide corner cases
    issue(0, 3'd4, 1, 0, 7, 0, 0, 10, 0);
    issue(0, 3'd6, 1, 0, 7, 0, 0, 11, 0);
    issue(0, 3'd4, 1, 0, 64'h8000_0000, 64'hFFFF_FFFF, 0, 12, 0);
    issue(0, 3'd6, 1, 0, 64'h8000_0000, 64'hFFFF_FFFF, 0, 13, 0);
    issue(0, 3'd4, 1, 0, 64'hFFFF_FFF9, 2, 0, 14, 0);
    issue(0, 3'd6, 1, 0, 64'hFFFF_FFF9, 2, 0, 15, 0);
    issue(0, 3'd5, 1, 0, 100, 0, 0, 16, 0);
    issue(0, 3'd7, 1, 0, 100, 0, 0, 17, 0);
    drain();

    // in_valid held during CALC with another rdi
    issue(0, 3'd4, 1, 0, 64'hFFFF_FFF9, 2, 0, 9, 0);
    acc0 = last_acc;
    issue(0, 3'd0, 0, 0, 1, 2, 0, 20, 1);
    chk("busy_next_accept_cycle", 64'(last_acc - acc0), 64'd34);
    drain();

    // Reset pulse in the middle of CALC aborts the op
    issue(0, 3'd0, 1, 0, 12345, 678, 0, 21, 1);
    in_valid32 = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_result", {32'h0, res32}, 64'h0);
    chk("abort_rd", 64'(rd32), 64'h0);
    chk("abort_memfetch", 64'(mf32), 64'h0);
    chk("abort_in_ready", 64'(rdy32), 64'h0);
    q32.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    issue(0, 3'd0, 0, 0, 40, 2, 0, 22, 0);
    drain();

    // Random XLEN=32 traffic
    for (int i = 0; i < 60; i++) begin
      issue(0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            rnd(32), rnd(32), $urandom_range(0, 31), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid32 = 1'b0;
        @(negedge clk);
      end
    end
    drain();

    // XLEN=64 instance
    issue(1, 3'd0, 1, 0, 123456789, 64'hFFFF_FFFF_FFFF_FFFB, 0, 3, 0);
    issue(1, 3'd1, 1, 0, 64'h8000_0000_0000_0000, 2, 0, 4, 1);
    drain();
    for (int i = 0; i < 15; i++) begin
      issue(1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rnd(64), rnd(64), $urandom_range(0, 63), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_ex_md.md
# riscv_ex_md

Parametrised execute stage with an iterative multiply/divide unit: single-cycle RV32I/RV64I ALU operations plus the RISC-V M-extension (MUL*, DIV*, REM*), behind a valid/ready input handshake. Sits between decode and writeback. The stage stalls decode via `in_ready` while a multi-cycle M operation is in flight. Outputs are registered and keep the existing `result`/`rd`/`memfetch` contract.

## Interface
- `XLEN`, 32: datapath width; legal values 32 and 64.
- `SHW`, $clog2(XLEN): shift-amount width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `in_valid`  in  1  decode presents an operation.
- `in_ready`  out  1  stage can accept; `rst & (state==IDLE)`.
- `rdi`  in  5  destination register.
- `a`, `b`  in  XLEN  operands.
- `shamt`  in  SHW  shift amount for SLL/SRL/SRA.
- `funct3`  in  3  operation select.
- `invertb`  in  1  ADD→SUB, SRL→SRA; ignored when `muldiv`=1.
- `muldiv`  in  1  selects the M-extension decode of `funct3`.
- `load`  in  1  operation is a load address computation.
- `result`  out  XLEN  registered result.
- `rd`  out  5  registered destination.
- `memfetch`  out  1  registered copy of `load`.
- `out_valid`  out  1  one-cycle pulse: `result`/`rd`/`memfetch` are new.

## Operation
- Accept occurs on an edge where `in_valid & in_ready`. Inputs are sampled only at accept.
- ALU decode (`muldiv`=0):
  - ADD: a+b, or a−b when `invertb`.
  - SLL: a<<shamt.
  - SLT: signed compare.
  - SLTU: unsigned compare.
  - XOR, OR, AND: bitwise.
  - SRL: a>>shamt, or arithmetic shift when `invertb`.
  - All results are modulo 2^XLEN.
- M decode (`muldiv`=1):
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: high half, signed×signed.
  - 010 MULHSU: high half, signed×unsigned.
  - 011 MULHU: high half, unsigned×unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- M algorithm: operands are converted to magnitudes at accept. Multiply is radix-2 shift-add into a 2·XLEN accumulator. Divide is radix-2 restoring. The sign of the result is corrected in FIX.
- Divide corner cases:
  - Divide by zero: quotient is all-ones; remainder is `a`.
  - Signed overflow (DIV of −2^(XLEN−1) by −1): quotient is −2^(XLEN−1); remainder is 0.
  - Both corner cases still take the full latency. There is no early-out.
- FSM:
  - IDLE: M accept → CALC, counter loaded with XLEN−1.
  - CALC: one bit per cycle; counter decrements. When counter==0 → FIX.
  - FIX: write outputs, pulse `out_valid` → IDLE.
  - An ALU accept stays in IDLE.
- `rd`/`memfetch` for an M op are latched at accept and presented at FIX.
- No output backpressure: writeback always consumes `out_valid`.

## Timing
- Reset values: `result`=0, `rd`=0, `memfetch`=0, `out_valid`=0, state=IDLE, counter=0.
- `in_ready`=0 while `rst` is low.
- ALU latency: accept at edge e → outputs and `out_valid`=1 after edge e.
- Back-to-back ALU ops are possible every cycle.
- M latency: accept at edge e.
  - CALC covers edges e+1..e+XLEN.
  - FIX registers outputs at edge e+XLEN+1, i.e. 33 cycles for XLEN=32.
- `in_ready`=0 from after edge e until after the FIX edge. A new accept is possible at edge e+XLEN+2.
- `out_valid` lasts exactly one cycle. `result`/`rd`/`memfetch` hold until the next write.
- Reset asserted mid-CALC: the operation is aborted, all outputs return to reset values, and no `out_valid` is produced for it.
- `in_valid` while busy: ignored, not queued.

## Structure
- Add `FUNCT3_MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM`, `REMU` defines to `riscv/isa.v`, next to the existing FUNCT3 ALU defines.
- Add FSM state encodings `EXMD_IDLE`, `EXMD_CALC`, `EXMD_FIX` as defines in the same file.
- Sub-module `riscv_muldiv`: iterative unit owning the counter, accumulator and sign fix-up. Handshake `start`/`done` (one-cycle pulse) toward the stage.
- The ALU stays inline in `riscv_ex_md`.

## Test plan
- Reset with `rst`=0: `result`=0, `rd`=0, `memfetch`=0, `out_valid`=0, `in_ready`=0. After release, `in_ready`=1.
- ALU stream on consecutive cycles:
  - rdi=4, 40+2 → 42, rd=4.
  - rdi=2, invertb, 40−5 → 35.
  - SLL 3<<2 → 12.
  - SRA of 0x80000000 by 4 → 0xF8000000.
  - Each result follows one cycle after its accept, with a single `out_valid` pulse.
- MUL −3×7 (XLEN=32):
  - `in_ready`=0 for 33 cycles.
  - Result 0xFFFFFFEB at cycle 33.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Divide corner cases:
  - DIV 7/0 → 0xFFFFFFFF.
  - REM 7/0 → 7.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM of the same → 0.
  - DIV −7/2 → −3.
  - REM −7/2 → −1.
- `in_valid` held high during CALC with a different `rdi`:
  - Ignored; the M result carries the latched rd.
  - The next op is accepted the cycle after FIX.
- Reset pulsed at CALC cycle 10:
  - Outputs go to 0, no `out_valid` for the aborted op.
  - After release, an ADD completes normally.
- Parameter run with XLEN=64:
  - MUL latency 65 cycles.
  - MULH 2^63×2 → 0xFFFFFFFFFFFFFFFF.
